// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt controller.
package exc_pkg;
  typedef enum logic [1:0] {S_RUN, S_HANDLER, S_LOCKUP} exc_state_t;

  localparam logic [1:0]  PCSEL_SEQ    = 2'b00;
  localparam logic [1:0]  PCSEL_VEC    = 2'b01;
  localparam logic [1:0]  PCSEL_ELR    = 2'b10;

  localparam logic [63:0] ESR_BAD_OPC  = 64'h1;
  localparam logic [63:0] ESR_IRQ      = 64'h2;
  localparam logic [63:0] ESR_BAD_ERET = 64'h3;

  // Handler entry point; the core's PC mux selects it when pc_sel == PCSEL_VEC.
  localparam logic [63:0] VECTOR_ADDR  = 64'h00000000000000D8;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: handler entry, ERET return and lockup sequencing.
// Outputs are combinational from state and inputs; state, irq_pend and sync flops are registered.
module exc_ctrl
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq,
  input  logic        bad_opcode,
  input  logic        eret,
  input  logic [63:0] pc,
  output logic [63:0] elr_d,
  output logic        elr_en,
  output logic [63:0] esr_d,
  output logic        esr_en,
  output logic [1:0]  pc_sel,
  output logic        exc_flush,
  output logic        irq_ack,
  output logic        in_handler,
  output logic        halt
);
  exc_state_t state_q, state_d;
  logic       irq_pend_q, irq_pend_d;
  logic       hist_q, hist_d;
  logic       irq_sync;
  logic       irq_rise;
  logic       irq_req;
  logic       take;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (reset),
    .d     (ext_irq),
    .q     (irq_sync)
  );

  assign irq_rise = irq_sync & ~hist_q;
  assign irq_req  = irq_pend_q | irq_rise;
  assign elr_d    = pc;
  assign esr_en   = elr_en;

  always_comb begin
    state_d    = state_q;
    irq_pend_d = irq_pend_q;
    hist_d     = irq_sync;
    take       = 1'b0;
    elr_en     = 1'b0;
    esr_d      = 64'h0;
    pc_sel     = PCSEL_SEQ;
    exc_flush  = 1'b0;
    irq_ack    = 1'b0;
    in_handler = 1'b0;
    halt       = 1'b0;
    if (reset) begin
      case (state_q)
        S_RUN: begin
          if (bad_opcode) begin
            take  = 1'b1;
            esr_d = ESR_BAD_OPC;
          end else if (eret) begin
            take  = 1'b1;
            esr_d = ESR_BAD_ERET;
          end else if (irq_req) begin
            take    = 1'b1;
            esr_d   = ESR_IRQ;
            irq_ack = 1'b1;
          end
          // A rise that lost to a fault is remembered; a taken irq consumes pending.
          if (irq_ack)       irq_pend_d = 1'b0;
          else if (irq_rise) irq_pend_d = 1'b1;
          if (take) begin
            elr_en    = 1'b1;
            exc_flush = 1'b1;
            pc_sel    = PCSEL_VEC;
            state_d   = S_HANDLER;
          end
        end
        S_HANDLER: begin
          in_handler = 1'b1;
          if (irq_rise) irq_pend_d = 1'b1;
          if (bad_opcode) begin
            exc_flush = 1'b1;
            state_d   = S_LOCKUP;
          end else if (eret) begin
            pc_sel  = PCSEL_ELR;
            state_d = S_RUN;
          end
        end
        S_LOCKUP: begin
          halt      = 1'b1;
          exc_flush = 1'b1;
          if (irq_rise) irq_pend_d = 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      irq_pend_q <= 1'b0;
      hist_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      hist_q     <= hist_d;
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// Per-cycle directed vector table for exc_ctrl, checked on the falling edge.
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ext_irq = 1'b0;
  logic        bad_opcode = 1'b0;
  logic        eret = 1'b0;
  logic [63:0] pc = 64'h0;
  logic [63:0] elr_d, esr_d;
  logic        elr_en, esr_en, exc_flush, irq_ack, in_handler, halt;
  logic [1:0]  pc_sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ext_irq    (ext_irq),
    .bad_opcode (bad_opcode),
    .eret       (eret),
    .pc         (pc),
    .elr_d      (elr_d),
    .elr_en     (elr_en),
    .esr_d      (esr_d),
    .esr_en     (esr_en),
    .pc_sel     (pc_sel),
    .exc_flush  (exc_flush),
    .irq_ack    (irq_ack),
    .in_handler (in_handler),
    .halt       (halt)
  );

  typedef struct {
    logic        rst;
    logic        irq;
    logic        bad;
    logic        er;
    logic [63:0] pc;
    logic        en;
    logic [63:0] esr;
    logic [1:0]  sel;
    logic        fl;
    logic        ack;
    logic        inh;
    logic        hlt;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(logic rst, logic irq, logic bad, logic er, logic [63:0] p,
                              logic en, logic [63:0] esr, logic [1:0] sel,
                              logic fl, logic ack, logic inh, logic hlt);
    vec_t v;
    v.rst = rst; v.irq = irq; v.bad = bad; v.er = er; v.pc = p;
    v.en = en; v.esr = esr; v.sel = sel; v.fl = fl; v.ack = ack; v.inh = inh; v.hlt = hlt;
    return v;
  endfunction

  task automatic chk(input int row, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  initial begin
    //                rst irq bad er  pc        en esr sel fl ack inh hlt
    // reset state and idle
    vec.push_back(mk(0, 0, 0, 0, 64'h000,  0, 0, 2'd0, 0, 0, 0, 0)); // 0
    vec.push_back(mk(1, 0, 0, 0, 64'h03C,  0, 0, 2'd0, 0, 0, 0, 0));
    // bad opcode in run, then handler
    vec.push_back(mk(1, 0, 1, 0, 64'h040,  1, 1, 2'd1, 1, 0, 0, 0)); // 2
    vec.push_back(mk(1, 0, 0, 0, 64'h0D8,  0, 0, 2'd0, 0, 0, 1, 0));
    // eret in handler returns
    vec.push_back(mk(1, 0, 0, 1, 64'h0DC,  0, 0, 2'd2, 0, 0, 1, 0)); // 4
    vec.push_back(mk(1, 0, 0, 0, 64'h044,  0, 0, 2'd0, 0, 0, 0, 0));
    // eret outside handler faults
    vec.push_back(mk(1, 0, 0, 1, 64'h008,  1, 3, 2'd1, 1, 0, 0, 0)); // 6
    vec.push_back(mk(1, 0, 0, 1, 64'h0D8,  0, 0, 2'd2, 0, 0, 1, 0));
    vec.push_back(mk(1, 0, 0, 0, 64'h00C,  0, 0, 2'd0, 0, 0, 0, 0));
    // irq rise in run: taken two edges after sampling, held level acks once
    vec.push_back(mk(1, 1, 0, 0, 64'h0F8,  0, 0, 2'd0, 0, 0, 0, 0)); // 9
    vec.push_back(mk(1, 1, 0, 0, 64'h0FC,  0, 0, 2'd0, 0, 0, 0, 0));
    vec.push_back(mk(1, 1, 0, 0, 64'h100,  1, 2, 2'd1, 1, 1, 0, 0)); // 11
    vec.push_back(mk(1, 1, 0, 0, 64'h0D8,  0, 0, 2'd0, 0, 0, 1, 0));
    vec.push_back(mk(1, 1, 0, 1, 64'h0DC,  0, 0, 2'd2, 0, 0, 1, 0));
    vec.push_back(mk(1, 1, 0, 0, 64'h104,  0, 0, 2'd0, 0, 0, 0, 0));
    vec.push_back(mk(1, 1, 0, 0, 64'h108,  0, 0, 2'd0, 0, 0, 0, 0));
    vec.push_back(mk(1, 0, 0, 0, 64'h10C,  0, 0, 2'd0, 0, 0, 0, 0)); // 16
    // irq rise masked in handler, taken right after eret
    vec.push_back(mk(1, 0, 1, 0, 64'h200,  1, 1, 2'd1, 1, 0, 0, 0)); // 17
    vec.push_back(mk(1, 1, 0, 0, 64'h0D8,  0, 0, 2'd0, 0, 0, 1, 0));
    vec.push_back(mk(1, 1, 0, 0, 64'h0DC,  0, 0, 2'd0, 0, 0, 1, 0));
    vec.push_back(mk(1, 1, 0, 0, 64'h0E0,  0, 0, 2'd0, 0, 0, 1, 0));
    vec.push_back(mk(1, 1, 0, 0, 64'h0E4,  0, 0, 2'd0, 0, 0, 1, 0));
    vec.push_back(mk(1, 1, 0, 1, 64'h0E8,  0, 0, 2'd2, 0, 0, 1, 0)); // 22
    vec.push_back(mk(1, 1, 0, 0, 64'h204,  1, 2, 2'd1, 1, 1, 0, 0)); // 23
    vec.push_back(mk(1, 0, 0, 1, 64'h0D8,  0, 0, 2'd2, 0, 0, 1, 0));
    vec.push_back(mk(1, 0, 0, 0, 64'h208,  0, 0, 2'd0, 0, 0, 0, 0));
    // bad opcode beats a same-cycle irq rise; irq follows the return
    vec.push_back(mk(1, 1, 0, 0, 64'h300,  0, 0, 2'd0, 0, 0, 0, 0)); // 26
    vec.push_back(mk(1, 1, 0, 0, 64'h304,  0, 0, 2'd0, 0, 0, 0, 0));
    vec.push_back(mk(1, 1, 1, 0, 64'h308,  1, 1, 2'd1, 1, 0, 0, 0)); // 28
    vec.push_back(mk(1, 1, 0, 1, 64'h0D8,  0, 0, 2'd2, 0, 0, 1, 0));
    vec.push_back(mk(1, 1, 0, 0, 64'h30C,  1, 2, 2'd1, 1, 1, 0, 0)); // 30
    vec.push_back(mk(1, 0, 0, 1, 64'h0D8,  0, 0, 2'd2, 0, 0, 1, 0));
    vec.push_back(mk(1, 0, 0, 0, 64'h310,  0, 0, 2'd0, 0, 0, 0, 0));
    // fault inside handler (bad+eret together) locks up until reset
    vec.push_back(mk(1, 0, 1, 0, 64'h400,  1, 1, 2'd1, 1, 0, 0, 0)); // 33
    vec.push_back(mk(1, 0, 1, 1, 64'h0D8,  0, 0, 2'd0, 1, 0, 1, 0)); // 34
    vec.push_back(mk(1, 1, 0, 0, 64'h0DC,  0, 0, 2'd0, 1, 0, 0, 1));
    vec.push_back(mk(1, 1, 1, 0, 64'h0E0,  0, 0, 2'd0, 1, 0, 0, 1));
    vec.push_back(mk(1, 1, 0, 1, 64'h0E4,  0, 0, 2'd0, 1, 0, 0, 1));
    vec.push_back(mk(1, 1, 0, 0, 64'h0E8,  0, 0, 2'd0, 1, 0, 0, 1));
    // reset mid-lockup drops the pending interrupt
    vec.push_back(mk(0, 0, 0, 0, 64'h000,  0, 0, 2'd0, 0, 0, 0, 0)); // 39
    vec.push_back(mk(1, 0, 0, 0, 64'h500,  0, 0, 2'd0, 0, 0, 0, 0));
    vec.push_back(mk(1, 0, 0, 0, 64'h504,  0, 0, 2'd0, 0, 0, 0, 0));
    vec.push_back(mk(1, 0, 0, 0, 64'h508,  0, 0, 2'd0, 0, 0, 0, 0));

    for (int i = 0; i < vec.size(); i++) begin
      if (i > 0) @(posedge clk);
      #1;
      reset      = vec[i].rst;
      ext_irq    = vec[i].irq;
      bad_opcode = vec[i].bad;
      eret       = vec[i].er;
      pc         = vec[i].pc;
      @(negedge clk);
      chk(i, "elr_en",     {63'h0, elr_en},     {63'h0, vec[i].en});
      chk(i, "esr_en",     {63'h0, esr_en},     {63'h0, vec[i].en});
      chk(i, "elr_d",      elr_d,               vec[i].pc);
      if (vec[i].en || !vec[i].rst)
        chk(i, "esr_d",    esr_d,               vec[i].esr);
      chk(i, "pc_sel",     {62'h0, pc_sel},     {62'h0, vec[i].sel});
      chk(i, "exc_flush",  {63'h0, exc_flush},  {63'h0, vec[i].fl});
      chk(i, "irq_ack",    {63'h0, irq_ack},    {63'h0, vec[i].ack});
      chk(i, "in_handler", {63'h0, in_handler}, {63'h0, vec[i].inh});
      chk(i, "halt",       {63'h0, halt},       {63'h0, vec[i].hlt});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
